// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types for the round-robin memory arbiter: RAM status encoding,
// arbiter FSM states and the default word width.
package mem_arb_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: combinational search for the first set bit of 'active', starting
// at 'ptr' and wrapping modulo NREQ. 'valid' is low when nothing is active.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] active,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int unsigned k;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    k     = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      k = (32'(ptr) + off) % NREQ;
      if (!valid && active[IW'(k)]) begin
        valid = 1'b1;
        idx   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-requester round-robin arbiter onto a single RAM port,
// one outstanding access. Optional watchdog abort with `ARB_WATCHDOG_EN.
module mem_arbiter_rr
  import mem_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 2,
  parameter int unsigned AW          = WORD_W,
  parameter int unsigned DW          = WORD_W,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [DW-1:0]            req_load,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic [DW-1:0]            ramload,
  input  logic [1:0]               ramstate,
  output logic                     arb_err
);

  localparam int unsigned GW = $clog2(NREQ);

  if (NREQ < 2 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_arbiter_rr: NREQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  arb_state_t      state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GW-1:0]   ptr_next, pick_idx;
  logic            pick_valid;
  logic [NREQ-1:0] active;
  logic            ram_access, timeout, done;

  assign active     = req_ren | req_wen;
  assign ram_access = (ramstate_t'(ramstate) == RAM_ACCESS);
  assign ptr_next   = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);

  rr_pick #(.NREQ(NREQ)) u_pick (
    .active (active),
    .ptr    (rr_ptr_q),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_q;

  // Held at zero outside BUSY, so BUSY cycle n sees n-1 stalled cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                  wd_q <= '0;
    else if (state_q != ST_BUSY) wd_q <= '0;
    else if (!ram_access)       wd_q <= wd_q + WD_W'(1);
  end

  assign timeout = (state_q == ST_BUSY) && !ram_access &&
                   (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    req_load = '0;
    arb_err  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        ramaddr  = req_addr[grant_q];
        ramstore = req_store[grant_q];
        ramWEN   = req_wen[grant_q];
        ramREN   = req_ren[grant_q] & ~req_wen[grant_q];
        req_load = ramload;
        // A requester that abandons its access releases the port silently.
        if (!active[grant_q]) begin
          state_d = ST_IDLE;
        end else if (ram_access) begin
          done     = 1'b1;
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end else if (timeout) begin
          done     = 1'b1;
          arb_err  = 1'b1;
          req_load = '0;
          rr_ptr_d = ptr_next;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_wait = active;
    if (done) req_wait[grant_q] = 1'b0;
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Scoreboard bench for mem_arbiter_rr (NREQ=4): directed requests feed a
// requester driver; a monitor checks every completion against expectations.
module tb_mem_arbiter_rr;
  import mem_arb_pkg::*;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;

  typedef struct {
    int          idx;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] data;
    bit          err;
    int          cyc;
  } txn_t;

  logic                    CLK = 1'b0;
  logic                    nRST;
  logic [NREQ-1:0]         req_ren = '0;
  logic [NREQ-1:0]         req_wen = '0;
  logic [NREQ-1:0][AW-1:0] req_addr = '0;
  logic [NREQ-1:0][DW-1:0] req_store = '0;
  logic [NREQ-1:0]         req_wait;
  logic [DW-1:0]           req_load, ramstore, ramload;
  logic [AW-1:0]           ramaddr;
  logic                    ramREN, ramWEN, arb_err;
  logic [1:0]              ramstate;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  txn_t plan [NREQ][8];
  int   phead  [NREQ] = '{default: 0};
  int   ptail  [NREQ] = '{default: 0};
  int   cmp_cnt[NREQ] = '{default: 0};
  int   seen   [NREQ] = '{default: 0};
  txn_t sb[$];
  txn_t mon_e;

  logic [AW-1:0] stall_addr = '1;
  int            stall_len  = 0;
  int            stall_used = 0;

  mem_arbiter_rr #(
    .NREQ        (NREQ),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .req_ren   (req_ren),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_store (req_store),
    .req_wait  (req_wait),
    .req_load  (req_load),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .arb_err   (arb_err)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM model: read data is addr ^ 0xDEADBEAF; one address may stall.
  assign ramload  = ramaddr ^ 32'hDEAD_BEAF;
  assign ramstate = !(ramREN | ramWEN) ? RAM_FREE :
                    (ramaddr == stall_addr && stall_used < stall_len) ? RAM_BUSY : RAM_ACCESS;

  always @(posedge CLK) begin
    if (!(ramREN | ramWEN))      stall_used <= 0;
    else if (ramstate == RAM_BUSY) stall_used <= stall_used + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic plan_req(input int i, input bit ren, input bit wen,
                          input logic [31:0] addr, input logic [31:0] store);
    txn_t t;
    t.idx = i; t.ren = ren; t.wen = wen; t.addr = addr; t.data = store;
    t.err = 1'b0; t.cyc = -1;
    plan[i][ptail[i]] = t;
    ptail[i]++;
  endtask

  task automatic expect_done(input int i, input bit ren, input bit wen, input logic [31:0] addr,
                             input logic [31:0] data, input bit err, input int at);
    txn_t t;
    t.idx = i; t.ren = ren; t.wen = wen; t.addr = addr; t.data = data;
    t.err = err; t.cyc = at;
    sb.push_back(t);
  endtask

  task automatic wait_drain(input int maxc, input string name);
    bit ok = 1'b0;
    for (int n = 0; n < maxc && !ok; n++) begin
      @(negedge CLK); #2;
      if (sb.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d completions outstanding after %0d cycles", name, sb.size(), maxc);
      sb.delete();
    end
    repeat (2) @(negedge CLK);
    #2;
  endtask

  // Requester driver: presents queued requests, drops one after it completes.
  always @(posedge CLK) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (cmp_cnt[i] != seen[i]) begin
        seen[i]    = cmp_cnt[i];
        req_ren[i] = 1'b0;
        req_wen[i] = 1'b0;
      end
      if (!(req_ren[i] | req_wen[i]) && phead[i] < ptail[i]) begin
        req_ren[i]   = plan[i][phead[i]].ren;
        req_wen[i]   = plan[i][phead[i]].wen;
        req_addr[i]  = plan[i][phead[i]].addr;
        req_store[i] = plan[i][phead[i]].data;
        phead[i]++;
      end
    end
  end

  // Monitor: every dropped wait on an active requester is a completion.
  always @(negedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < NREQ; i++) begin
        if ((req_ren[i] | req_wen[i]) && !req_wait[i]) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: requester %0d at cycle %0d, none expected", i, cyc);
          end else begin
            mon_e = sb.pop_front();
            check("grant_idx", i, mon_e.idx);
            check("ramaddr", ramaddr, mon_e.addr);
            check("ramWEN", {31'b0, ramWEN}, {31'b0, mon_e.wen});
            check("ramREN", {31'b0, ramREN}, {31'b0, mon_e.ren & ~mon_e.wen});
            if (mon_e.wen) check("ramstore", ramstore, mon_e.data);
            else           check("req_load", req_load, mon_e.data);
            check("arb_err", {31'b0, arb_err}, {31'b0, mon_e.err});
            if (mon_e.cyc >= 0) check("done_cycle", cyc, mon_e.cyc);
          end
          cmp_cnt[i]++;
        end
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: bench did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int c;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_ramREN",   {31'b0, ramREN}, 32'h0);
    check("rst_ramWEN",   {31'b0, ramWEN}, 32'h0);
    check("rst_ramaddr",  ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_arb_err",  {31'b0, arb_err}, 32'h0);
    check("rst_req_load", req_load, 32'h0);
    check("rst_req_wait", {28'b0, req_wait}, 32'h0);
    nRST = 1'b1;
    @(negedge CLK); #2;

    // Single read, zero-wait RAM: completes two cycles after being presented.
    c = cyc;
    plan_req(1, 1, 0, 32'h0000_0040, 32'h0);
    expect_done(1, 1, 0, 32'h0000_0040, 32'hDEAD_BEEF, 0, c + 2);
    wait_drain(20, "single_read");

    // ren and wen together: write wins. rr_ptr=2, search 2,3,0 finds 0.
    c = cyc;
    plan_req(0, 1, 1, 32'h0000_0080, 32'h1234_5678);
    expect_done(0, 1, 1, 32'h0000_0080, 32'h1234_5678, 0, c + 2);
    wait_drain(20, "write_prio");

    // Reset during a stalled read: strobes drop at once, request re-served.
    stall_addr = 32'h0000_00C0;
    stall_len  = 3;
    plan_req(3, 1, 0, 32'h0000_00C0, 32'h0);
    expect_done(3, 1, 0, 32'h0000_00C0, 32'hDEAD_BE6F, 0, -1);
    begin
      bit seen_ren = 1'b0;
      for (int n = 0; n < 20 && !seen_ren; n++) begin
        @(negedge CLK);
        if (ramREN) seen_ren = 1'b1;
      end
      check("mid_rst_busy_seen", {31'b0, seen_ren}, 32'h1);
    end
    #2;
    nRST = 1'b0;
    #1;
    check("mid_rst_ramREN",  {31'b0, ramREN}, 32'h0);
    check("mid_rst_ramWEN",  {31'b0, ramWEN}, 32'h0);
    check("mid_rst_ramaddr", ramaddr, 32'h0);
    check("mid_rst_wait3",   {31'b0, req_wait[3]}, 32'h1);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    wait_drain(30, "reset_reissue");
    stall_len = 0;

    // All four requesting continuously from rr_ptr=0 (wrapped after index 3).
    c = cyc;
    for (int i = 0; i < NREQ; i++) begin
      plan_req(i, 1, 0, 32'h0000_0100 + 32'(4 * i), 32'h0);
      plan_req(i, 0, 1, 32'h0000_0200 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    end
    expect_done(0, 1, 0, 32'h0000_0100, 32'hDEAD_BFAF, 0, c + 2);
    expect_done(1, 1, 0, 32'h0000_0104, 32'hDEAD_BFAB, 0, c + 4);
    expect_done(2, 1, 0, 32'h0000_0108, 32'hDEAD_BFA7, 0, c + 6);
    expect_done(3, 1, 0, 32'h0000_010C, 32'hDEAD_BFA3, 0, c + 8);
    expect_done(0, 0, 1, 32'h0000_0200, 32'hA000_0000, 0, c + 10);
    expect_done(1, 0, 1, 32'h0000_0204, 32'hA000_0001, 0, c + 12);
    expect_done(2, 0, 1, 32'h0000_0208, 32'hA000_0002, 0, c + 14);
    expect_done(3, 0, 1, 32'h0000_020C, 32'hA000_0003, 0, c + 16);
    wait_drain(40, "round_robin");

    // RAM stalls 5 cycles on requester 0; requester 2 must stay blocked.
    stall_addr = 32'h0000_0304;
    stall_len  = 5;
    c = cyc;
    plan_req(0, 1, 0, 32'h0000_0304, 32'h0);
    plan_req(2, 1, 0, 32'h0000_0300, 32'h0);
    expect_done(0, 1, 0, 32'h0000_0304, 32'hDEAD_BDAB, 0, c + 7);
    expect_done(2, 1, 0, 32'h0000_0300, 32'hDEAD_BDAF, 0, c + 9);
    wait_drain(30, "ram_stall");

`ifdef ARB_WATCHDOG_EN
    // RAM stuck on requester 1 (rr_ptr=3 -> 1): abort in BUSY cycle 8.
    stall_addr = 32'h0000_0500;
    stall_len  = 1000;
    c = cyc;
    plan_req(1, 1, 0, 32'h0000_0500, 32'h0);
    plan_req(2, 1, 0, 32'h0000_0504, 32'h0);
    expect_done(1, 1, 0, 32'h0000_0500, 32'h0000_0000, 1, c + 9);
    expect_done(2, 1, 0, 32'h0000_0504, 32'hDEAD_BBAB, 0, c + 11);
    wait_drain(40, "watchdog");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
